// File: rtl/stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM state encoding, EVAL decode and the
// stage-control output bundle.
package stall_ctrl_pkg;

  localparam int unsigned INIT_CNT_W  = 8;
  localparam int unsigned FLUSH_CNT_W = 8;
  localparam int unsigned STALL_CNT_W = 8;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_RUN      = 3'd1,
    S_STALL    = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_FLUSH    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    EV_FREEZE,
    EV_BRANCH,
    EV_HAZARD,
    EV_NONE
  } eval_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_HAZARD = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  // Priority: memory freeze, then taken branch, then hazard.
  function automatic eval_t eval_sel(input logic mem_busy, input logic branch_taken,
                                     input logic hazard_detected);
    eval_t ev;
    ev = EV_NONE;
    if (mem_busy)             ev = EV_FREEZE;
    else if (branch_taken)    ev = EV_BRANCH;
    else if (hazard_detected) ev = EV_HAZARD;
    return ev;
  endfunction

  function automatic ctrl_t eval_ctrl(input eval_t ev);
    ctrl_t c;
    c = CTRL_RUN;
    unique case (ev)
      EV_FREEZE: c = CTRL_FREEZE;
      EV_BRANCH: c = CTRL_BRANCH;
      EV_HAZARD: c = CTRL_HAZARD;
      EV_NONE:   c = CTRL_RUN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/branch/memory status in and stage-register control out for the stall controller.
interface pipeline_stall_controller_if;

  logic hazard_detected;
  logic branch_taken;
  logic mem_busy;
  logic pc_en;
  logic if_id_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_en;
  logic mem_wb_en;
  logic stall_timeout;

  // Pipeline side: reports status, consumes control.
  modport master (
    output hazard_detected, branch_taken, mem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, stall_timeout
  );

  // Controller side.
  modport slave (
    input  hazard_detected, branch_taken, mem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, stall_timeout
  );

endinterface

// File: rtl/stall_perf_counter.sv
// Saturating enable counter used for stall/flush performance statistics.
module stall_perf_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline-control sequencer for the 5-stage core: Mealy stage enables/flushes, stall watchdog.
// Define STALL_PERF_EN to add the stall_cycles/flush_cycles performance counters.
module pipeline_stall_controller
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES  = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 15
`ifdef STALL_PERF_EN
  ,
  parameter int unsigned CNT_W        = 32
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipeline_stall_controller_if.slave  ctrl
`ifdef STALL_PERF_EN
  ,
  output logic [CNT_W-1:0]            stall_cycles,
  output logic [CNT_W-1:0]            flush_cycles
`endif
);

  localparam logic [INIT_CNT_W-1:0]  InitLast  = INIT_CNT_W'(INIT_CYCLES - 1);
  localparam logic [FLUSH_CNT_W-1:0] FlushLast = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [STALL_CNT_W-1:0] StallMax  = STALL_CNT_W'(MAX_STALL);
  localparam logic                   FlushMulti = (FLUSH_CYCLES > 1);

  state_t                 state_q, state_d;
  logic [INIT_CNT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   stall_timeout_q, stall_timeout_d;
  logic                   timeout_set;
  eval_t                  ev;
  ctrl_t                  ctrl_s;

  assign ev = eval_sel(ctrl.mem_busy, ctrl.branch_taken, ctrl.hazard_detected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_INIT;
      init_cnt_q      <= '0;
      flush_cnt_q     <= '0;
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = '0;
    timeout_set = 1'b0;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q >= InitLast) begin
          state_d = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      // In S_MEM_WAIT a busy memory decodes to EV_FREEZE, so the same EVAL covers waiting
      // and the exit cycle.
      S_RUN, S_STALL, S_MEM_WAIT: begin
        unique case (ev)
          EV_FREEZE: state_d = S_MEM_WAIT;
          EV_BRANCH: begin
            state_d     = FlushMulti ? S_FLUSH : S_RUN;
            flush_cnt_d = FLUSH_CNT_W'(1);
          end
          EV_HAZARD: begin
            state_d     = S_STALL;
            stall_cnt_d = (stall_cnt_q >= StallMax) ? StallMax : stall_cnt_q + 1'b1;
            timeout_set = (stall_cnt_d == StallMax);
          end
          EV_NONE:   state_d = S_RUN;
        endcase
      end
      S_FLUSH: begin
        if (ctrl.mem_busy) begin
          state_d = S_FLUSH;
        end else if (ctrl.branch_taken) begin
          state_d     = FlushMulti ? S_FLUSH : S_RUN;
          flush_cnt_d = FLUSH_CNT_W'(1);
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q >= FlushLast) begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
    stall_timeout_d = stall_timeout_q | timeout_set;
  end

  always_comb begin
    ctrl_s = CTRL_INIT;
    if (rst_n) begin
      case (state_q)
        S_RUN, S_STALL, S_MEM_WAIT: ctrl_s = eval_ctrl(ev);
        S_FLUSH: begin
          if (ctrl.mem_busy)          ctrl_s = CTRL_FREEZE;
          else if (ctrl.branch_taken) ctrl_s = CTRL_BRANCH;
          else                        ctrl_s = CTRL_FLUSH;
        end
        default: ctrl_s = CTRL_INIT;
      endcase
    end
  end

  assign ctrl.pc_en         = ctrl_s.pc_en;
  assign ctrl.if_id_en      = ctrl_s.if_id_en;
  assign ctrl.if_id_flush   = ctrl_s.if_id_flush;
  assign ctrl.id_ex_flush   = ctrl_s.id_ex_flush;
  assign ctrl.ex_mem_en     = ctrl_s.ex_mem_en;
  assign ctrl.mem_wb_en     = ctrl_s.mem_wb_en;
  // Timeout is visible in the very cycle the stall count reaches its limit.
  assign ctrl.stall_timeout = stall_timeout_q | timeout_set;

`ifdef STALL_PERF_EN
  logic stall_en;
  logic flush_en;

  assign stall_en = !ctrl_s.pc_en &&
                    ((state_q == S_RUN) || (state_q == S_STALL) || (state_q == S_MEM_WAIT));
  assign flush_en = ctrl_s.if_id_flush && (state_q != S_INIT);

  stall_perf_counter #(
    .Width (CNT_W)
  ) u_stall_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .count (stall_cycles)
  );

  stall_perf_counter #(
    .Width (CNT_W)
  ) u_flush_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_en),
    .count (flush_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller (FLUSH_CYCLES=3 instance).
module tb_pipeline_stall_controller;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [5:0] C_INIT   = 6'b001100;
  localparam logic [5:0] C_FREEZE = 6'b000000;
  localparam logic [5:0] C_BRANCH = 6'b111111;
  localparam logic [5:0] C_HAZARD = 6'b000111;
  localparam logic [5:0] C_RUN    = 6'b110011;
  localparam logic [5:0] C_FLUSH  = 6'b111011;

  logic clk;
  logic rst_n;
  logic [5:0] outs;
  int n_checks;
  int n_fail;

  pipeline_stall_controller_if bus ();

`ifdef STALL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
  logic [31:0] snap;
`endif

  pipeline_stall_controller #(
    .INIT_CYCLES  (4),
    .FLUSH_CYCLES (3),
    .MAX_STALL    (15)
`ifdef STALL_PERF_EN
    ,
    .CNT_W        (32)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
`ifdef STALL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  assign outs = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_en,
                 bus.mem_wb_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge, return mid-cycle ready to sample Mealy outputs.
  task automatic drive(input logic h, input logic b, input logic m);
    @(posedge clk);
    #1;
    bus.hazard_detected = h;
    bus.branch_taken    = b;
    bus.mem_busy        = m;
    #3;
  endtask

  task automatic release_and_init();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    check_eq("init_c0", 32'(outs), 32'(C_INIT));
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      check_eq("init_hold", 32'(outs), 32'(C_INIT));
    end
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    rst_n               = 1'b0;
    bus.hazard_detected = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.mem_busy        = 1'b0;

    // Reset and post-reset hold
    repeat (3) @(posedge clk);
    #4;
    check_eq("reset_outs", 32'(outs), 32'(C_INIT));
    check_eq("reset_timeout", 32'(bus.stall_timeout), 32'(0));
    bus.hazard_detected = 1'b1;
    bus.branch_taken    = 1'b1;
    #1;
    check_eq("reset_ignores_in", 32'(outs), 32'(C_INIT));
`ifdef STALL_PERF_EN
    check_eq("reset_perf_stall", stall_cycles, 32'd0);
    check_eq("reset_perf_flush", flush_cycles, 32'd0);
`endif
    release_and_init();
    drive(1'b0, 1'b0, 1'b0);
    check_eq("first_run", 32'(outs), 32'(C_RUN));

    // Single-cycle hazard
`ifdef STALL_PERF_EN
    snap = stall_cycles;
`endif
    drive(1'b1, 1'b0, 1'b0);
    check_eq("hazard_1cyc", 32'(outs), 32'(C_HAZARD));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("hazard_after", 32'(outs), 32'(C_RUN));
    check_eq("hazard_no_to", 32'(bus.stall_timeout), 32'(0));
`ifdef STALL_PERF_EN
    check_eq("perf_stall_inc", stall_cycles, snap + 32'd1);
`endif

    // Long hazard -> watchdog
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      check_eq("long_haz_outs", 32'(outs), 32'(C_HAZARD));
      check_eq("long_haz_to", 32'(bus.stall_timeout), 32'(i >= 15));
    end
    drive(1'b0, 1'b0, 1'b0);
    check_eq("to_release_outs", 32'(outs), 32'(C_RUN));
    check_eq("to_sticky", 32'(bus.stall_timeout), 32'(1));

    // Branch beats hazard; two further flush cycles
`ifdef STALL_PERF_EN
    snap = flush_cycles;
`endif
    drive(1'b1, 1'b1, 1'b0);
    check_eq("br_vs_haz", 32'(outs), 32'(C_BRANCH));
    drive(1'b1, 1'b0, 1'b0);
    check_eq("flush_2", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("flush_3", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("flush_done", 32'(outs), 32'(C_RUN));
`ifdef STALL_PERF_EN
    check_eq("perf_flush_inc", flush_cycles, snap + 32'd3);
`endif

    // Memory wait with branch ignored, branch on release
    drive(1'b0, 1'b0, 1'b1);
    check_eq("mw_c1", 32'(outs), 32'(C_FREEZE));
    drive(1'b0, 1'b1, 1'b1);
    check_eq("mw_c2_br", 32'(outs), 32'(C_FREEZE));
    for (int i = 3; i <= 5; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      check_eq("mw_hold", 32'(outs), 32'(C_FREEZE));
    end
    drive(1'b0, 1'b1, 1'b0);
    check_eq("mw_exit_br", 32'(outs), 32'(C_BRANCH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("mw_flush_2", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("mw_flush_3", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("mw_flush_done", 32'(outs), 32'(C_RUN));

    // Memory busy inside flush: count holds, completes after release
    drive(1'b0, 1'b1, 1'b0);
    check_eq("fm_branch", 32'(outs), 32'(C_BRANCH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("fm_flush_2", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b1, 1'b1);
    check_eq("fm_freeze_1", 32'(outs), 32'(C_FREEZE));
    drive(1'b1, 1'b0, 1'b1);
    check_eq("fm_freeze_2", 32'(outs), 32'(C_FREEZE));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("fm_flush_3", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("fm_done", 32'(outs), 32'(C_RUN));

    // New branch during flush restarts the count
    drive(1'b0, 1'b1, 1'b0);
    check_eq("rs_branch", 32'(outs), 32'(C_BRANCH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("rs_flush_2", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b1, 1'b0);
    check_eq("rs_rebranch", 32'(outs), 32'(C_BRANCH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("rs_flush_a", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("rs_flush_b", 32'(outs), 32'(C_FLUSH));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("rs_done", 32'(outs), 32'(C_RUN));

    // Memory beats branch and hazard; hazard taken on memory release
    drive(1'b1, 1'b1, 1'b1);
    check_eq("mem_prio", 32'(outs), 32'(C_FREEZE));
    drive(1'b1, 1'b0, 1'b0);
    check_eq("mw_exit_haz", 32'(outs), 32'(C_HAZARD));
    drive(1'b0, 1'b0, 1'b0);
    check_eq("mw_haz_done", 32'(outs), 32'(C_RUN));

    // Reset mid-run acts immediately and discards pending stall
    drive(1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_haz", 32'(outs), 32'(C_HAZARD));
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrun_rst_outs", 32'(outs), 32'(C_INIT));
    check_eq("midrun_rst_to", 32'(bus.stall_timeout), 32'(0));
    bus.hazard_detected = 1'b0;
    repeat (2) @(posedge clk);
    release_and_init();
    drive(1'b0, 1'b0, 1'b0);
    check_eq("rerun", 32'(outs), 32'(C_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
